// File: rtl/unidade_controle_param_pkg.sv
// Shared types for the parametrised image-coprocessor control unit:
// algorithm codes, FSM state encoding and the zoom-direction helper.
package unidade_controle_pkg;

  typedef enum logic [1:0] {
    ALG_REPLICACAO = 2'b00,
    ALG_DECIMACAO  = 2'b01,
    ALG_VIZINHO    = 2'b10,
    ALG_MEDIA      = 2'b11
  } alg_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    ACK   = 3'd2,
    ARM   = 3'd3,
    RUN   = 3'd4,
    SHOW  = 3'd5
  } estado_e;

  // Replication and nearest-neighbour enlarge; decimation and block-average shrink.
  function automatic logic is_zoom_in(input logic [1:0] alg);
    return (alg == ALG_REPLICACAO) || (alg == ALG_VIZINHO);
  endfunction

endpackage

// File: rtl/unidade_controle_param_if.sv
// HPS pixel-write handshake between the bridge (master) and the control unit (slave).
interface unidade_controle_param_if #(
  parameter int ORIG_AW = 15,
  parameter int PIX_W   = 8
);
  logic               wr_req;
  logic [ORIG_AW-1:0] wr_addr;
  logic [PIX_W-1:0]   wr_data;
  logic               wr_done;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_done);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_done);
endinterface

// File: rtl/unidade_controle_param_gerador_endereco_vga.sv
// Registered VGA window test and read-address generation for the original
// and result image RAMs (one cycle from pix_x/pix_y).
module gerador_endereco_vga #(
  parameter int LARG_ORIG = 160,
  parameter int ALT_ORIG  = 120,
  parameter int COORD_W   = 10,
  parameter int ORIG_AW   = 15,
  parameter int RES_AW    = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COORD_W-1:0] img_w,
  input  logic [COORD_W-1:0] img_h,
  input  logic [COORD_W-1:0] x_off,
  input  logic [COORD_W-1:0] y_off,
  input  logic               blank,
  output logic               in_bounds,
  output logic [ORIG_AW-1:0] rd_addr_orig,
  output logic [RES_AW-1:0]  rd_addr_res
);

  localparam int PW = 2 * COORD_W;

  logic [COORD_W-1:0] dx_s, dy_s;
  logic               inside_s, orig_ok_s;
  logic               in_bounds_d, in_bounds_q;
  logic [ORIG_AW-1:0] rd_addr_orig_d, rd_addr_orig_q;
  logic [RES_AW-1:0]  rd_addr_res_d, rd_addr_res_q;

  // Window compare and address arithmetic; out-of-window addresses collapse to 0.
  always_comb begin
    dx_s      = pix_x - x_off;
    dy_s      = pix_y - y_off;
    inside_s  = (pix_x >= x_off) && (dx_s < img_w) && (pix_y >= y_off) && (dy_s < img_h);
    orig_ok_s = inside_s && (dx_s < COORD_W'(LARG_ORIG)) && (dy_s < COORD_W'(ALT_ORIG));
    in_bounds_d = inside_s && !blank;
    if (inside_s) begin
      rd_addr_res_d = RES_AW'(PW'(dy_s) * PW'(img_w) + PW'(dx_s));
    end else begin
      rd_addr_res_d = {RES_AW{1'b0}};
    end
    if (orig_ok_s) begin
      rd_addr_orig_d = ORIG_AW'(PW'(dy_s) * PW'(LARG_ORIG) + PW'(dx_s));
    end else begin
      rd_addr_orig_d = {ORIG_AW{1'b0}};
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_bounds_q    <= 1'b0;
      rd_addr_orig_q <= {ORIG_AW{1'b0}};
      rd_addr_res_q  <= {RES_AW{1'b0}};
    end else begin
      in_bounds_q    <= in_bounds_d;
      rd_addr_orig_q <= rd_addr_orig_d;
      rd_addr_res_q  <= rd_addr_res_d;
    end
  end

  assign in_bounds    = in_bounds_q;
  assign rd_addr_orig = rd_addr_orig_q;
  assign rd_addr_res  = rd_addr_res_q;

endmodule

// File: rtl/unidade_controle_param.sv
// Top-level sequencer: HPS writes into mem1, resize geometry/launch, VGA readout.
// Optional CENTER_CROP_EN adds crop_x0/crop_y0 so clipped enlargements stay centred.
module unidade_controle_param
  import unidade_controle_pkg::*;
#(
  parameter int LARG_ORIG = 160,
  parameter int ALT_ORIG  = 120,
  parameter int MAX_LARG  = 320,
  parameter int MAX_ALT   = 240,
  parameter int TELA_LARG = 640,
  parameter int TELA_ALT  = 480,
  parameter int PIX_W     = 8,
  parameter int ZOOM_W    = 2,
  parameter int COORD_W   = 10,
  parameter int ORIG_AW   = 15,
  parameter int RES_AW    = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               alg,
  input  logic [ZOOM_W-1:0]        zoom,
  unidade_controle_param_if.slave  hps,
  output logic                     mem1_wren,
  output logic [ORIG_AW-1:0]       mem1_wraddr,
  output logic [PIX_W-1:0]         mem1_wdata,
  output logic                     redim_start,
  output logic [1:0]               redim_alg,
  output logic [ZOOM_W-1:0]        redim_zoom,
  input  logic                     redim_done,
  output logic [COORD_W-1:0]       img_w,
  output logic [COORD_W-1:0]       img_h,
  output logic [COORD_W-1:0]       x_off,
  output logic [COORD_W-1:0]       y_off,
`ifdef CENTER_CROP_EN
  output logic [COORD_W-1:0]       crop_x0,
  output logic [COORD_W-1:0]       crop_y0,
`endif
  input  logic [COORD_W-1:0]       pix_x,
  input  logic [COORD_W-1:0]       pix_y,
  output logic [ORIG_AW-1:0]       rd_addr_orig,
  output logic [RES_AW-1:0]        rd_addr_res,
  output logic                     src_sel,
  output logic                     in_bounds,
  output logic                     busy,
  output logic                     ready,
  output logic                     err
);

  // Wide enough that LARG_ORIG << max zoom never overflows.
  localparam int GW = COORD_W + (1 << ZOOM_W);
  localparam logic [GW-1:0]      LARG_G = GW'(LARG_ORIG);
  localparam logic [GW-1:0]      ALT_G  = GW'(ALT_ORIG);
  localparam logic [GW-1:0]      MAXL_G = GW'(MAX_LARG);
  localparam logic [GW-1:0]      MAXA_G = GW'(MAX_ALT);
  localparam logic [GW-1:0]      TELL_G = GW'(TELA_LARG);
  localparam logic [GW-1:0]      TELA_G = GW'(TELA_ALT);
  localparam logic [COORD_W-1:0] W0  = COORD_W'(LARG_ORIG);
  localparam logic [COORD_W-1:0] H0  = COORD_W'(ALT_ORIG);
  localparam logic [COORD_W-1:0] XO0 = COORD_W'((TELA_LARG - LARG_ORIG) / 2);
  localparam logic [COORD_W-1:0] YO0 = COORD_W'((TELA_ALT - ALT_ORIG) / 2);

  estado_e            state_q, state_d, ret_q, ret_d;
  logic               arm_ph_q, arm_ph_d;
  logic [GW-1:0]      new_w_q, new_w_d, new_h_q, new_h_d;
  logic [GW-1:0]      sh_w_s, sh_h_s;
  logic               mem1_wren_q, mem1_wren_d;
  logic [ORIG_AW-1:0] mem1_wraddr_q, mem1_wraddr_d;
  logic [PIX_W-1:0]   mem1_wdata_q, mem1_wdata_d;
  logic               wr_done_q, wr_done_d;
  logic               redim_start_q, redim_start_d;
  logic [1:0]         redim_alg_q, redim_alg_d;
  logic [ZOOM_W-1:0]  redim_zoom_q, redim_zoom_d;
  logic [COORD_W-1:0] img_w_q, img_w_d, img_h_q, img_h_d;
  logic [COORD_W-1:0] x_off_q, x_off_d, y_off_q, y_off_d;
  logic               src_sel_q, src_sel_d, busy_q, busy_d;
  logic               ready_q, ready_d, err_q, err_d;
  logic [COORD_W-1:0] geo_w_s, geo_h_s, geo_x_s, geo_y_s;
`ifdef CENTER_CROP_EN
  logic [COORD_W-1:0] crop_x0_q, crop_x0_d, crop_y0_q, crop_y0_d;
`endif

  // Next-state and registered-output computation for the control FSM.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    arm_ph_d      = arm_ph_q;
    new_w_d       = new_w_q;
    new_h_d       = new_h_q;
    mem1_wren_d   = 1'b0;
    mem1_wraddr_d = mem1_wraddr_q;
    mem1_wdata_d  = mem1_wdata_q;
    wr_done_d     = 1'b0;
    redim_start_d = 1'b0;
    redim_alg_d   = redim_alg_q;
    redim_zoom_d  = redim_zoom_q;
    img_w_d       = img_w_q;
    img_h_d       = img_h_q;
    x_off_d       = x_off_q;
    y_off_d       = y_off_q;
    ready_d       = 1'b0;
    err_d         = 1'b0;
`ifdef CENTER_CROP_EN
    crop_x0_d     = crop_x0_q;
    crop_y0_d     = crop_y0_q;
`endif
    sh_w_s = LARG_G << redim_zoom_q;
    sh_h_s = ALT_G << redim_zoom_q;

    case (state_q)
      IDLE, SHOW: begin
        if (hps.wr_req) begin
          state_d       = WRITE;
          ret_d         = state_q;
          mem1_wren_d   = 1'b1;
          mem1_wraddr_d = hps.wr_addr;
          mem1_wdata_d  = hps.wr_data;
        end else if (start) begin
          state_d      = ARM;
          ret_d        = state_q;
          arm_ph_d     = 1'b0;
          redim_alg_d  = alg;
          redim_zoom_d = zoom;
        end else begin
          state_d = state_q;
        end
      end
      WRITE: begin
        state_d   = ACK;
        wr_done_d = 1'b1;
      end
      ACK: begin
        state_d = ret_q;
      end
      ARM: begin
        if (!arm_ph_q) begin
          arm_ph_d = 1'b1;
          if (is_zoom_in(redim_alg_q)) begin
            new_w_d = (sh_w_s > MAXL_G) ? MAXL_G : sh_w_s;
            new_h_d = (sh_h_s > MAXA_G) ? MAXA_G : sh_h_s;
          end else begin
            new_w_d = LARG_G >> redim_zoom_q;
            new_h_d = ALT_G >> redim_zoom_q;
          end
        end else begin
          arm_ph_d = 1'b0;
          if ((new_w_q == {GW{1'b0}}) || (new_h_q == {GW{1'b0}})) begin
            // Committed geometry is left untouched on a degenerate request.
            err_d   = 1'b1;
            state_d = ret_q;
          end else begin
            img_w_d       = COORD_W'(new_w_q);
            img_h_d       = COORD_W'(new_h_q);
            x_off_d       = COORD_W'((TELL_G - new_w_q) >> 1);
            y_off_d       = COORD_W'((TELA_G - new_h_q) >> 1);
            redim_start_d = 1'b1;
            state_d       = RUN;
`ifdef CENTER_CROP_EN
            if (is_zoom_in(redim_alg_q)) begin
              crop_x0_d = COORD_W'(((sh_w_s - new_w_q) >> redim_zoom_q) >> 1);
              crop_y0_d = COORD_W'(((sh_h_s - new_h_q) >> redim_zoom_q) >> 1);
            end else begin
              crop_x0_d = {COORD_W{1'b0}};
              crop_y0_d = {COORD_W{1'b0}};
            end
`endif
          end
        end
      end
      RUN: begin
        if (redim_done) begin
          ready_d = 1'b1;
          state_d = SHOW;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d    = state_d inside {ARM, RUN, WRITE, ACK};
    // The result stays on screen while a write or re-arm launched from SHOW is in flight.
    src_sel_d = (state_d == SHOW) ||
                ((state_d inside {WRITE, ACK, ARM}) && (ret_d == SHOW));
  end

  // Control FSM state and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ret_q         <= IDLE;
      arm_ph_q      <= 1'b0;
      new_w_q       <= {GW{1'b0}};
      new_h_q       <= {GW{1'b0}};
      mem1_wren_q   <= 1'b0;
      mem1_wraddr_q <= {ORIG_AW{1'b0}};
      mem1_wdata_q  <= {PIX_W{1'b0}};
      wr_done_q     <= 1'b0;
      redim_start_q <= 1'b0;
      redim_alg_q   <= 2'b00;
      redim_zoom_q  <= {ZOOM_W{1'b0}};
      img_w_q       <= W0;
      img_h_q       <= H0;
      x_off_q       <= XO0;
      y_off_q       <= YO0;
      src_sel_q     <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
`ifdef CENTER_CROP_EN
      crop_x0_q     <= {COORD_W{1'b0}};
      crop_y0_q     <= {COORD_W{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      arm_ph_q      <= arm_ph_d;
      new_w_q       <= new_w_d;
      new_h_q       <= new_h_d;
      mem1_wren_q   <= mem1_wren_d;
      mem1_wraddr_q <= mem1_wraddr_d;
      mem1_wdata_q  <= mem1_wdata_d;
      wr_done_q     <= wr_done_d;
      redim_start_q <= redim_start_d;
      redim_alg_q   <= redim_alg_d;
      redim_zoom_q  <= redim_zoom_d;
      img_w_q       <= img_w_d;
      img_h_q       <= img_h_d;
      x_off_q       <= x_off_d;
      y_off_q       <= y_off_d;
      src_sel_q     <= src_sel_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      err_q         <= err_d;
`ifdef CENTER_CROP_EN
      crop_x0_q     <= crop_x0_d;
      crop_y0_q     <= crop_y0_d;
`endif
    end
  end

  // In IDLE the original image is shown with the power-on geometry.
  always_comb begin
    if (state_q == IDLE) begin
      geo_w_s = W0;
      geo_h_s = H0;
      geo_x_s = XO0;
      geo_y_s = YO0;
    end else begin
      geo_w_s = img_w_q;
      geo_h_s = img_h_q;
      geo_x_s = x_off_q;
      geo_y_s = y_off_q;
    end
  end

  gerador_endereco_vga #(
    .LARG_ORIG (LARG_ORIG),
    .ALT_ORIG  (ALT_ORIG),
    .COORD_W   (COORD_W),
    .ORIG_AW   (ORIG_AW),
    .RES_AW    (RES_AW)
  ) u_gerador (
    .clk          (clk),
    .reset        (reset),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .img_w        (geo_w_s),
    .img_h        (geo_h_s),
    .x_off        (geo_x_s),
    .y_off        (geo_y_s),
    .blank        (state_d == RUN),
    .in_bounds    (in_bounds),
    .rd_addr_orig (rd_addr_orig),
    .rd_addr_res  (rd_addr_res)
  );

  assign hps.wr_done  = wr_done_q;
  assign mem1_wren    = mem1_wren_q;
  assign mem1_wraddr  = mem1_wraddr_q;
  assign mem1_wdata   = mem1_wdata_q;
  assign redim_start  = redim_start_q;
  assign redim_alg    = redim_alg_q;
  assign redim_zoom   = redim_zoom_q;
  assign img_w        = img_w_q;
  assign img_h        = img_h_q;
  assign x_off        = x_off_q;
  assign y_off        = y_off_q;
  assign src_sel      = src_sel_q;
  assign busy         = busy_q;
  assign ready        = ready_q;
  assign err          = err_q;
`ifdef CENTER_CROP_EN
  assign crop_x0      = crop_x0_q;
  assign crop_y0      = crop_y0_q;
`endif

endmodule

// File: tb/tb_unidade_controle_param.sv
// Scoreboard bench for unidade_controle_param: default instance plus a
// LARG_ORIG=4 instance used to provoke the zero-size error path.
module tb_unidade_controle_param;

  localparam int COORD_W = 10;
  localparam int ORIG_AW = 15;
  localparam int RES_AW  = 19;
  localparam int PIX_W   = 8;
  localparam int ZOOM_W  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [COORD_W-1:0] pix_x, pix_y;

  logic               start_a, redim_done_a;
  logic [1:0]         alg_a;
  logic [ZOOM_W-1:0]  zoom_a;
  logic               mem1_wren_a, redim_start_a, src_sel_a, in_bounds_a, busy_a, ready_a, err_a;
  logic [ORIG_AW-1:0] mem1_wraddr_a, rd_addr_orig_a;
  logic [PIX_W-1:0]   mem1_wdata_a;
  logic [1:0]         redim_alg_a;
  logic [ZOOM_W-1:0]  redim_zoom_a;
  logic [COORD_W-1:0] img_w_a, img_h_a, x_off_a, y_off_a;
  logic [RES_AW-1:0]  rd_addr_res_a;

  logic               start_b, redim_done_b;
  logic [1:0]         alg_b;
  logic [ZOOM_W-1:0]  zoom_b;
  logic               mem1_wren_b, redim_start_b, src_sel_b, in_bounds_b, busy_b, ready_b, err_b;
  logic [ORIG_AW-1:0] mem1_wraddr_b, rd_addr_orig_b;
  logic [PIX_W-1:0]   mem1_wdata_b;
  logic [1:0]         redim_alg_b;
  logic [ZOOM_W-1:0]  redim_zoom_b;
  logic [COORD_W-1:0] img_w_b, img_h_b, x_off_b, y_off_b;
  logic [RES_AW-1:0]  rd_addr_res_b;
`ifdef CENTER_CROP_EN
  logic [COORD_W-1:0] crop_x0_a, crop_y0_a, crop_x0_b, crop_y0_b;
`endif

  unidade_controle_param_if #(.ORIG_AW(ORIG_AW), .PIX_W(PIX_W)) hps_a ();
  unidade_controle_param_if #(.ORIG_AW(ORIG_AW), .PIX_W(PIX_W)) hps_b ();

  unidade_controle_param dut_a (
    .clk(clk), .reset(reset), .start(start_a), .alg(alg_a), .zoom(zoom_a), .hps(hps_a),
    .mem1_wren(mem1_wren_a), .mem1_wraddr(mem1_wraddr_a), .mem1_wdata(mem1_wdata_a),
    .redim_start(redim_start_a), .redim_alg(redim_alg_a), .redim_zoom(redim_zoom_a),
    .redim_done(redim_done_a), .img_w(img_w_a), .img_h(img_h_a), .x_off(x_off_a), .y_off(y_off_a),
`ifdef CENTER_CROP_EN
    .crop_x0(crop_x0_a), .crop_y0(crop_y0_a),
`endif
    .pix_x(pix_x), .pix_y(pix_y), .rd_addr_orig(rd_addr_orig_a), .rd_addr_res(rd_addr_res_a),
    .src_sel(src_sel_a), .in_bounds(in_bounds_a), .busy(busy_a), .ready(ready_a), .err(err_a)
  );

  unidade_controle_param #(.LARG_ORIG(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .alg(alg_b), .zoom(zoom_b), .hps(hps_b),
    .mem1_wren(mem1_wren_b), .mem1_wraddr(mem1_wraddr_b), .mem1_wdata(mem1_wdata_b),
    .redim_start(redim_start_b), .redim_alg(redim_alg_b), .redim_zoom(redim_zoom_b),
    .redim_done(redim_done_b), .img_w(img_w_b), .img_h(img_h_b), .x_off(x_off_b), .y_off(y_off_b),
`ifdef CENTER_CROP_EN
    .crop_x0(crop_x0_b), .crop_y0(crop_y0_b),
`endif
    .pix_x(pix_x), .pix_y(pix_y), .rd_addr_orig(rd_addr_orig_b), .rd_addr_res(rd_addr_res_b),
    .src_sel(src_sel_b), .in_bounds(in_bounds_b), .busy(busy_b), .ready(ready_b), .err(err_b)
  );

  typedef struct packed { logic [ORIG_AW-1:0] addr; logic [PIX_W-1:0] data; } wr_exp_t;
  typedef struct packed { logic [COORD_W-1:0] w, h, xo, yo; } geo_exp_t;

  wr_exp_t  wr_q[$];
  geo_exp_t geo_q[$];
  wr_exp_t  we;
  geo_exp_t ge;
  int n_tests  = 0;
  int n_fail   = 0;
  int wren_cnt = 0;
  int rs_cnt_a = 0;
  int rs_cnt_b = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop expectations whenever the DUT emits a write or a launch.
  always @(negedge clk) begin
    if (reset && mem1_wren_a) begin
      wren_cnt++;
      if (wr_q.size() == 0) begin
        check_eq("unexpected_write", wr_q.size(), 1);
      end else begin
        we = wr_q.pop_front();
        check_eq("mem1_wraddr", mem1_wraddr_a, we.addr);
        check_eq("mem1_wdata", mem1_wdata_a, we.data);
      end
    end
    if (reset && redim_start_a) begin
      rs_cnt_a++;
      if (geo_q.size() == 0) begin
        check_eq("unexpected_redim_start", geo_q.size(), 1);
      end else begin
        ge = geo_q.pop_front();
        check_eq("img_w", img_w_a, ge.w);
        check_eq("img_h", img_h_a, ge.h);
        check_eq("x_off", x_off_a, ge.xo);
        check_eq("y_off", y_off_a, ge.yo);
      end
    end
    if (reset && redim_start_b) rs_cnt_b++;
  end

  task automatic do_write(input logic [ORIG_AW-1:0] a, input logic [PIX_W-1:0] d);
    int k = 0;
    wr_q.push_back('{addr: a, data: d});
    hps_a.wr_req  = 1'b1;
    hps_a.wr_addr = a;
    hps_a.wr_data = d;
    do begin
      @(negedge clk);
      k++;
    end while (!hps_a.wr_done && k < 10);
    check_eq("wr_done_latency", k, 2);
    check_eq("busy_in_ack", busy_a, 1);
    hps_a.wr_req = 1'b0;
  endtask

  task automatic wait_rs_a();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!redim_start_a && k < 20);
    check_eq("redim_start_seen", redim_start_a, 1);
  endtask

  task automatic finish_run();
    redim_done_a = 1'b1;
    @(negedge clk);
    redim_done_a = 1'b0;
    check_eq("ready_pulse", ready_a, 1);
    check_eq("src_sel_show", src_sel_a, 1);
    check_eq("busy_show", busy_a, 0);
    @(negedge clk);
    check_eq("ready_one_cycle", ready_a, 0);
  endtask

  task automatic run_resize(input logic [1:0] a, input logic [ZOOM_W-1:0] z,
                            input logic [COORD_W-1:0] w, input logic [COORD_W-1:0] h,
                            input logic [COORD_W-1:0] xo, input logic [COORD_W-1:0] yo);
    geo_q.push_back('{w: w, h: h, xo: xo, yo: yo});
    alg_a = a; zoom_a = z; start_a = 1'b1;
    wait_rs_a();
    start_a = 1'b0;
    check_eq("redim_alg", redim_alg_a, a);
    check_eq("redim_zoom", redim_zoom_a, z);
    @(negedge clk);
    check_eq("busy_run", busy_a, 1);
    check_eq("src_sel_run", src_sel_a, 0);
    finish_run();
  endtask

  task automatic pix_check(input int x, input int y, input logic ib,
                           input int ao, input int ar, input string tag);
    pix_x = COORD_W'(x);
    pix_y = COORD_W'(y);
    @(negedge clk);
    check_eq({tag, "_in_bounds"}, in_bounds_a, ib);
    check_eq({tag, "_rd_addr_orig"}, rd_addr_orig_a, ao);
    check_eq({tag, "_rd_addr_res"}, rd_addr_res_a, ar);
  endtask

  initial begin
    int k;
    reset = 1'b0;
    start_a = 1'b0; alg_a = 2'b00; zoom_a = 2'd0; redim_done_a = 1'b0;
    start_b = 1'b0; alg_b = 2'b00; zoom_b = 2'd0; redim_done_b = 1'b0;
    pix_x = 10'd0; pix_y = 10'd0;
    hps_a.wr_req = 1'b0; hps_a.wr_addr = 15'd0; hps_a.wr_data = 8'd0;
    hps_b.wr_req = 1'b0; hps_b.wr_addr = 15'd0; hps_b.wr_data = 8'd0;
    repeat (3) @(negedge clk);

    check_eq("rst_img_w", img_w_a, 160);
    check_eq("rst_img_h", img_h_a, 120);
    check_eq("rst_x_off", x_off_a, 240);
    check_eq("rst_y_off", y_off_a, 180);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_src_sel", src_sel_a, 0);
    check_eq("rst_mem1_wren", mem1_wren_a, 0);
    check_eq("rst_wr_done", hps_a.wr_done, 0);
    check_eq("rst_b_img_w", img_w_b, 4);
    check_eq("rst_b_x_off", x_off_b, 318);

    reset = 1'b1;
    pix_check(240, 180, 1'b1, 0, 0, "pix_origin");
    check_eq("pix_origin_src_sel", src_sel_a, 0);
    pix_check(399, 299, 1'b1, 19199, 19199, "pix_last");
    pix_check(400, 180, 1'b0, 0, 0, "pix_right_out");
    pix_check(239, 180, 1'b0, 0, 0, "pix_left_out");

    // Zero-size request on the narrow instance.
    alg_b = 2'b11; zoom_b = 2'd3; start_b = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!err_b && k < 20);
    start_b = 1'b0;
    check_eq("err_latency", k, 3);
    check_eq("err_b_img_w", img_w_b, 4);
    check_eq("err_b_img_h", img_h_b, 120);
    check_eq("err_b_x_off", x_off_b, 318);
    check_eq("err_b_y_off", y_off_b, 180);
    @(negedge clk);
    check_eq("err_one_cycle", err_b, 0);
    check_eq("err_b_busy", busy_b, 0);
    check_eq("err_b_no_launch", rs_cnt_b, 0);

    // Single write, then no repeat once wr_req drops.
    do_write(15'h0123, 8'hAB);
    repeat (4) @(negedge clk);
    check_eq("single_write_count", wren_cnt, 1);
    check_eq("idle_after_write", busy_a, 0);

    // Write and start together: write first, then the 4x enlargement.
    geo_q.push_back('{w: 10'd320, h: 10'd240, xo: 10'd160, yo: 10'd120});
    alg_a = 2'b00; zoom_a = 2'd2; start_a = 1'b1;
    do_write(15'h0456, 8'h5C);
    wait_rs_a();
    check_eq("write_before_arm", wren_cnt, 2);
    pix_x = 10'd200; pix_y = 10'd150;
    repeat (3) @(negedge clk);
    check_eq("run_busy", busy_a, 1);
    check_eq("run_src_sel", src_sel_a, 0);
    check_eq("run_blank", in_bounds_a, 0);
    check_eq("start_ignored_in_run", rs_cnt_a, 1);
    // start is still high, so SHOW immediately re-arms the same resize.
    geo_q.push_back('{w: 10'd320, h: 10'd240, xo: 10'd160, yo: 10'd120});
    finish_run();
    start_a = 1'b0;
    check_eq("rearm_busy", busy_a, 1);
    check_eq("rearm_src_sel", src_sel_a, 1);
    wait_rs_a();
    finish_run();
    check_eq("launch_count", rs_cnt_a, 2);

    pix_check(160, 120, 1'b1, 0, 0, "res_origin");
    pix_check(479, 359, 1'b1, 0, 76799, "res_last");
    pix_check(200, 130, 1'b1, 1640, 3240, "res_mid");
    pix_check(159, 120, 1'b0, 0, 0, "res_left_out");

    // Write while showing the result returns to SHOW.
    do_write(15'h7FFF, 8'h01);
    repeat (2) @(negedge clk);
    check_eq("show_after_write", src_sel_a, 1);
    check_eq("write_count_show", wren_cnt, 3);

    run_resize(2'b01, 2'd3, 10'd20, 10'd15, 10'd310, 10'd232);
    pix_check(310, 232, 1'b1, 0, 0, "dec_origin");
    pix_check(329, 246, 1'b1, 2259, 299, "dec_last");
    pix_check(330, 232, 1'b0, 0, 0, "dec_right_out");
    run_resize(2'b11, 2'd1, 10'd80, 10'd60, 10'd280, 10'd210);
    run_resize(2'b10, 2'd1, 10'd320, 10'd240, 10'd160, 10'd120);

    // Asynchronous reset in the middle of RUN.
    geo_q.push_back('{w: 10'd320, h: 10'd240, xo: 10'd160, yo: 10'd120});
    alg_a = 2'b00; zoom_a = 2'd1; start_a = 1'b1;
    wait_rs_a();
    start_a = 1'b0;
    @(negedge clk);
    check_eq("pre_reset_busy", busy_a, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_busy", busy_a, 0);
    check_eq("async_src_sel", src_sel_a, 0);
    check_eq("async_img_w", img_w_a, 160);
    check_eq("async_img_h", img_h_a, 120);
    check_eq("async_x_off", x_off_a, 240);
    check_eq("async_y_off", y_off_a, 180);
    check_eq("async_in_bounds", in_bounds_a, 0);
    @(negedge clk);
    reset = 1'b1;
    redim_done_a = 1'b1;
    @(negedge clk);
    redim_done_a = 1'b0;
    @(negedge clk);
    check_eq("no_ready_after_reset", ready_a, 0);
    check_eq("idle_after_reset", busy_a, 0);

    check_eq("writes_pending", wr_q.size(), 0);
    check_eq("launches_pending", geo_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
